// File: rtl/sht_sensor_responder_pkg.sv
// sht_sensor_responder_pkg: command codes, FSM states and CRC-8 helper for the SHT responder
package sht_sensor_responder_pkg;
  localparam logic [7:0] CMD_MEAS_T   = 8'h03;
  localparam logic [7:0] CMD_MEAS_H   = 8'h05;
  localparam logic [7:0] CMD_SOFT_RST = 8'h1E;
  localparam logic [7:0] CRC_POLY     = 8'h31;
  typedef enum logic [3:0] {
    S_IDLE, S_START_ARM, S_RX_CMD, S_ACK_CMD, S_MEAS,
    S_TX_MSB, S_ACK_M, S_TX_LSB, S_ACK_M2, S_TX_CRC
  } state_e;
  function automatic logic cmd_known(input logic [7:0] c);
    return c inside {CMD_MEAS_T, CMD_MEAS_H, CMD_SOFT_RST};
  endfunction
  function automatic logic [7:0] crc8(input logic [7:0] crc, input logic [7:0] b);
    logic [7:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) c = {c[6:0], 1'b0} ^ ((c[7] ^ b[i]) ? CRC_POLY : 8'h00);
    return c;
  endfunction
endpackage

// File: rtl/sht_sensor_responder_if.sv
// sht_sensor_responder_if: SHT 2-wire link; sck and resolved data line from the master side,
// drv/oe are the sensor's pad drive (oe=0 means the sensor releases DATA to high-z)
interface sht_sensor_responder_if;
  logic sck;
  logic data;
  logic drv;
  logic oe;
  modport master (output sck, data, input drv, oe);
  modport slave (input sck, data, output drv, oe);
endinterface

// File: rtl/sht_sensor_responder_line_sync.sv
// sht_sensor_responder_line_sync: SCK/DATA synchronizers with one-clk edge pulses
// in: clk, rst_n, sck_i, data_i  out: sck_s_o, data_s_o, sck/data rise/fall pulses
module sht_sensor_responder_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sck_i,
  input  logic data_i,
  output logic sck_s_o,
  output logic data_s_o,
  output logic sck_rise_o,
  output logic sck_fall_o,
  output logic data_rise_o,
  output logic data_fall_o
);
  logic [SYNC_STAGES-1:0] sck_q, data_q;
  logic sck_p_q, data_p_q;
  // DATA idles high (pull-up), so its chain resets to 1 to avoid a false edge after reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sck_q    <= '0;
      data_q   <= '1;
      sck_p_q  <= 1'b0;
      data_p_q <= 1'b1;
    end else begin
      sck_q    <= {sck_q[SYNC_STAGES-2:0], sck_i};
      data_q   <= {data_q[SYNC_STAGES-2:0], data_i};
      sck_p_q  <= sck_q[SYNC_STAGES-1];
      data_p_q <= data_q[SYNC_STAGES-1];
    end
  assign sck_s_o     = sck_q[SYNC_STAGES-1];
  assign data_s_o    = data_q[SYNC_STAGES-1];
  assign sck_rise_o  = sck_s_o & ~sck_p_q;
  assign sck_fall_o  = ~sck_s_o & sck_p_q;
  assign data_rise_o = data_s_o & ~data_p_q;
  assign data_fall_o = ~data_s_o & data_p_q;
endmodule

// File: rtl/sht_sensor_responder.sv
// sht_sensor_responder: device-side SHT sensor model answering commands on the 2-wire link
// in: clk, rst_n, bus(slave), temp_val_i, humid_val_i  out: cmd_o, cmd_valid_o, busy_o, err_o
module sht_sensor_responder
  import sht_sensor_responder_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MEAS_CYCLES = 1000,
  parameter int CNT_W       = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  sht_sensor_responder_if.slave        bus,
  input  logic [15:0]                  temp_val_i,
  input  logic [15:0]                  humid_val_i,
  output logic [7:0]                   cmd_o,
  output logic                         cmd_valid_o,
  output logic                         busy_o,
  output logic                         err_o
);
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (MEAS_CYCLES < 1 || MEAS_CYCLES >= (1 << CNT_W)) begin : g_bad_meas
    $error("MEAS_CYCLES must be in 1 .. 2**CNT_W-1");
  end
  localparam logic [CNT_W-1:0] TMR_LAST = CNT_W'(MEAS_CYCLES - 1);
  logic sck_s, data_s, sck_rise, sck_fall, data_rise, data_fall;
  sht_sensor_responder_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .rst_n(rst_n), .sck_i(bus.sck), .data_i(bus.data),
    .sck_s_o(sck_s), .data_s_o(data_s), .sck_rise_o(sck_rise), .sck_fall_o(sck_fall),
    .data_rise_o(data_rise), .data_fall_o(data_fall)
  );
  state_e st_q;
  logic [7:0] sh_q, cmd_q, crc_q, lsb_q;
  logic [3:0] cnt_q;
  logic [CNT_W-1:0] tmr_q;
  logic sel_q, oe_q, drv_q, cv_q, busy_q, err_q;
  logic start, meas_cmd;
  logic [15:0] word;
  assign start    = data_fall && sck_s;
  assign meas_cmd = cmd_q == CMD_MEAS_T || cmd_q == CMD_MEAS_H;
  // bit15 is forced low: it is the "ready" marker the master sees when busy ends
  assign word     = (sel_q ? temp_val_i : humid_val_i) & 16'h7FFF;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st_q   <= S_IDLE;
      sh_q   <= '0;
      cmd_q  <= '0;
      crc_q  <= '0;
      lsb_q  <= '0;
      cnt_q  <= '0;
      tmr_q  <= '0;
      sel_q  <= 1'b0;
      oe_q   <= 1'b0;
      drv_q  <= 1'b0;
      cv_q   <= 1'b0;
      busy_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      cv_q  <= 1'b0;
      err_q <= 1'b0;
      // a start outranks every other event, including a timer expiry in the same cycle
      if (start) begin
        st_q   <= S_START_ARM;
        oe_q   <= 1'b0;
        busy_q <= 1'b0;
        cnt_q  <= '0;
        tmr_q  <= '0;
        err_q  <= st_q inside {S_TX_MSB, S_ACK_M, S_TX_LSB};
      end else begin
        case (st_q)
          S_START_ARM: if (data_rise && sck_s) begin
            st_q  <= S_RX_CMD;
            cnt_q <= '0;
          end
          S_RX_CMD: if (sck_rise) begin
            sh_q  <= {sh_q[6:0], data_s};
            cnt_q <= cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cmd_q <= {sh_q[6:0], data_s};
              cv_q  <= 1'b1;
              st_q  <= S_ACK_CMD;
            end
          end
          // cnt 8: waiting for the 8th fall to place the ack; cnt 9: the 9th fall ends it
          S_ACK_CMD: if (sck_fall) begin
            if (cnt_q == 4'd8) begin
              oe_q  <= cmd_known(cmd_q);
              drv_q <= 1'b0;
              err_q <= !cmd_known(cmd_q);
              cnt_q <= 4'd9;
            end else begin
              cnt_q  <= '0;
              tmr_q  <= '0;
              oe_q   <= meas_cmd;
              drv_q  <= 1'b1;
              busy_q <= meas_cmd;
              sel_q  <= cmd_q == CMD_MEAS_T;
              st_q   <= meas_cmd ? S_MEAS : S_IDLE;
            end
          end
          S_MEAS: if (tmr_q == TMR_LAST) begin
            st_q   <= S_TX_MSB;
            busy_q <= 1'b0;
            drv_q  <= word[15];
            sh_q   <= word[15:8] << 1;
            lsb_q  <= word[7:0];
            crc_q  <= crc8(crc8(crc8(8'h00, cmd_q), word[15:8]), word[7:0]);
            cnt_q  <= 4'd1;
          end else tmr_q <= tmr_q + 1'b1;
          // cnt counts bits already placed on DATA; the fall after the 8th bit releases
          S_TX_MSB, S_TX_LSB, S_TX_CRC: if (sck_fall) begin
            if (cnt_q == 4'd8) begin
              oe_q <= 1'b0;
              st_q <= st_q == S_TX_MSB ? S_ACK_M : st_q == S_TX_LSB ? S_ACK_M2 : S_IDLE;
            end else begin
              oe_q  <= 1'b1;
              drv_q <= sh_q[7];
              sh_q  <= sh_q << 1;
              cnt_q <= cnt_q + 4'd1;
            end
          end
          S_ACK_M, S_ACK_M2: if (sck_rise) begin
            st_q  <= data_s ? S_IDLE : st_q == S_ACK_M ? S_TX_LSB : S_TX_CRC;
            sh_q  <= st_q == S_ACK_M ? lsb_q : crc_q;
            cnt_q <= '0;
          end
          default: ;
        endcase
      end
    end
  assign bus.oe      = oe_q;
  assign bus.drv     = drv_q;
  assign cmd_o       = cmd_q;
  assign cmd_valid_o = cv_q;
  assign busy_o      = busy_q;
  assign err_o       = err_q;
endmodule
